// File: rtl/isa_pkg.sv
// Shared ISA definitions: instruction field widths and opcode constants used by
// the loader, the instruction RAM and the decoder.
package isa_pkg;

    localparam int INSTR_W = 17;
    localparam int OPC_W   = 5;
    localparam int OPR_W   = 12;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_LDIAC = 5'd5;
    localparam opcode_t OP_NOP   = 5'd28;
    localparam opcode_t OP_CLAC  = 5'd30;
    localparam opcode_t OP_ENDOP = 5'd31;

    function automatic opcode_t get_opcode(input logic [INSTR_W-1:0] instr);
        return instr[INSTR_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/instr_loader.sv
// Byte-stream program loader: packs 3 big-endian bytes per instruction and writes
// instruction RAM from address 0 until endop. Optional trailing checksum: INSTR_LOADER_CSUM_EN.
module instr_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W = 11
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [INSTR_W-1:0]  wr_data,
    output logic                load_busy,
    output logic                load_done,
    output logic                load_err,
    output logic                cpu_start,
    output logic [ADDR_W:0]     word_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_B0    = 3'd1,
        ST_B1    = 3'd2,
        ST_B2    = 3'd3,
        ST_WRITE = 3'd4,
`ifdef INSTR_LOADER_CSUM_EN
        ST_CSUM  = 3'd5,
`endif
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    count_q, count_d;
    logic               b0_q, b0_d;
    logic [7:0]         b1_q, b1_d;
    logic [7:0]         b2_q, b2_d;
    logic               cpu_start_q, cpu_start_d;
`ifdef INSTR_LOADER_CSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               rx_take;
    logic [INSTR_W-1:0] word;

    assign word    = {b0_q, b1_q, b2_q};
    assign rx_take = rx_valid && rx_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        b0_d     = b0_q;
        b1_d     = b1_q;
        b2_d     = b2_q;
        rx_ready = 1'b0;
        wr_en    = 1'b0;
`ifdef INSTR_LOADER_CSUM_EN
        csum_d   = csum_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_start) begin
                    state_d = ST_B0;
                    addr_d  = '0;
                    count_d = '0;
`ifdef INSTR_LOADER_CSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_B0: begin
                rx_ready = 1'b1;
                if (rx_take) begin
                    // Only bit 0 carries instruction data; anything above is a framing error.
                    if (rx_data[7:1] != 7'd0) begin
                        state_d = ST_ERR;
                    end else begin
                        b0_d    = rx_data[0];
                        state_d = ST_B1;
                    end
`ifdef INSTR_LOADER_CSUM_EN
                    csum_d = csum_q ^ rx_data;
`endif
                end
            end
            ST_B1: begin
                rx_ready = 1'b1;
                if (rx_take) begin
                    b1_d    = rx_data;
                    state_d = ST_B2;
`ifdef INSTR_LOADER_CSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                end
            end
            ST_B2: begin
                rx_ready = 1'b1;
                if (rx_take) begin
                    b2_d    = rx_data;
                    state_d = ST_WRITE;
`ifdef INSTR_LOADER_CSUM_EN
                    csum_d  = csum_q ^ rx_data;
`endif
                end
            end
            ST_WRITE: begin
                wr_en   = 1'b1;
                count_d = count_q + (ADDR_W+1)'(1);
                addr_d  = addr_q + ADDR_W'(1);
                if (get_opcode(word) == OP_ENDOP) begin
`ifdef INSTR_LOADER_CSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d = ST_DONE;
`endif
                end else if (addr_q == {ADDR_W{1'b1}}) begin
                    // Last RAM slot consumed without endop: program does not fit.
                    state_d = ST_ERR;
                end else begin
                    state_d = ST_B0;
                end
            end
`ifdef INSTR_LOADER_CSUM_EN
            ST_CSUM: begin
                rx_ready = 1'b1;
                if (rx_take) begin
                    state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        cpu_start_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            count_q     <= '0;
            b0_q        <= 1'b0;
            b1_q        <= '0;
            b2_q        <= '0;
            cpu_start_q <= 1'b0;
`ifdef INSTR_LOADER_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            count_q     <= count_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            cpu_start_q <= cpu_start_d;
`ifdef INSTR_LOADER_CSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign wr_addr    = addr_q;
    assign wr_data    = word;
    assign word_count = count_q;
    assign cpu_start  = cpu_start_q;
    assign load_done  = (state_q == ST_DONE);
    assign load_err   = (state_q == ST_ERR);
`ifdef INSTR_LOADER_CSUM_EN
    assign load_busy  = (state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2) ||
                        (state_q == ST_WRITE) || (state_q == ST_CSUM);
`else
    assign load_busy  = (state_q == ST_B0) || (state_q == ST_B1) || (state_q == ST_B2) ||
                        (state_q == ST_WRITE);
`endif

endmodule
